itof_pipe: RTL and testbench
============================

Name: itof_pipe

Overview:
- Parametrised, fully handshaked integer-to-binary32 converter; successor to the fixed 32-bit signed 3-stage converter in the FPU.
- Accepts signed or unsigned integers of configurable width, selectable per transaction.
- Rounds correctly to nearest-even using full guard/round/sticky information.
- 3-stage valid/ready pipeline with per-stage stall and bubble collapse; sits between the integer register file read port and the FPU writeback arbiter.

Parameters:
- IW, 32, input integer width in bits; legal range 2..64.

Ports:
- clk  input  1  clock, all state on rising edge
- rstn  input  1  synchronous active-low reset
- in_valid  input  1  input transaction present
- in_ready  output  1  block can accept an input this cycle
- in_data  input  IW  integer operand
- in_unsigned  input  1  1: in_data is unsigned; 0: two's complement
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  32  IEEE-754 binary32 result

Behaviour:
- Reset: rstn sampled low at a rising edge clears all stage valid bits and data registers. out_valid=0, out_data=0, in_ready=1 in the cycle after reset. Reset mid-operation discards every in-flight transaction; no partial output.
- Handshake: transfer occurs on an edge where valid&&ready. out_data is held stable while out_valid=1 and out_ready=0.
- Stage enables:
  - Stage 3 loads when !v3 || out_ready.
  - Stage 2 loads when !v2 || stage-3 load.
  - Stage 1 loads when !v1 || stage-2 load.
  - in_ready = stage-1 load enable, combinational from valids and out_ready.
  - Bubbles collapse: an empty stage never stalls the stages behind it.
- Latency: input accepted at edge k appears with out_valid=1 after edge k+3 when out_ready is held high. Throughput is 1 per cycle. Ordering is strictly preserved.
- S1 (abs):
  - sign = !in_unsigned && in_data[IW-1].
  - mag = sign ? -in_data : in_data, held in IW bits zero-extended.
  - Signed minimum (-2^(IW-1)) yields mag = 2^(IW-1), which is correct as unsigned.
- S2 (normalise):
  - p = index of leading one of mag.
  - Left-shift mag so the leading one is at bit IW-1; fraction = next 23 bits (zero-padded when p<23).
  - guard = next bit; sticky = OR of all remaining lower bits.
  - Biased exponent e = 127 + p, 8 bits, maximum 127+63=190, so no overflow is possible.
  - mag==0 sets a zero flag.
- S3 (round):
  - inc = guard && (sticky || fraction[0]).
  - {carry, frac'} = fraction + inc.
  - On carry: frac'=0 and e=e+1.
  - out = {sign, e, frac'}. Zero flag forces 0x00000000 (+0.0), never -0.0.
- in_unsigned is captured with in_data and travels with it; changing it while a transaction is stalled has no effect on in-flight data.
- Simultaneous accept and emit in one cycle with a full pipeline is legal and sustains throughput.

Optional Feature:
- Macro ITOF_PIPE_INEXACT_EN.
- Defined: adds port out_inexact, output, 1 bit, = guard||sticky of the result. It is pipelined with the data, reset to 0, and held with out_data under stall.
- Undefined: the port is absent and no guard/sticky-OR register is retained beyond the rounding logic.

Test Plan:
- IW=32, signed inputs 1, -1, 0 → 0x3F800000, 0xBF800000, 0x00000000. Each out_valid exactly 3 cycles after accept with out_ready=1.
- IW=32, signed 0x80000000 → 0xCF000000; unsigned 0x80000000 → 0x4F000000; unsigned 0xFFFFFFFF → 0x4F800000 (round carries into exponent).
- Tie cases: 0x01000001 → 0x4B800000 (tie, down to even); 0x01000003 → 0x4B800002 (tie, up to even); 0x01000005 → 0x4B800002 (tie, down to even). With the macro defined, out_inexact=1 for all three; 0x01000000 → 0x4B800000 with out_inexact=0.
- Backpressure: stream 5 back-to-back inputs 1..5 with out_ready=0 for 6 cycles. in_ready drops after 3 accepted, out_data holds 0x3F800000, then all 5 results emerge in order with no loss or duplication.
- Bubbles: inputs with in_valid toggled 1,0,1, out_ready=1. Results appear with matching gaps. Then hold out_ready=0 for 1 cycle; the bubble collapses and in_ready stays 1.
- Reset mid-stream: assert rstn=0 for 1 cycle with 3 in flight. out_valid=0 next cycle, no stale result ever emitted. IW=16 build: unsigned 0xFFFF → 0x477FFF00.

Source files
------------

// File: rtl/itof_pipe.sv
// itof_pipe: handshaked integer-to-binary32 converter, round-to-nearest-even.
// Stages: S1 absolute value, S2 normalise, S3 round. Capacity 3 transactions.
// Optional: define ITOF_PIPE_INEXACT_EN to add the out_inexact output.
module itof_pipe #(
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_unsigned,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data
`ifdef ITOF_PIPE_INEXACT_EN
  ,
  output logic          out_inexact
`endif
);

  localparam int XW = IW + 24;

  logic            ld1, ld2, ld3;
  logic            v1, v2, v3;

  logic            s1_sign;
  logic [IW-1:0]   s1_mag;

  logic            s2_sign, s2_zero, s2_guard, s2_sticky;
  logic [7:0]      s2_exp;
  logic [22:0]     s2_frac;

  logic [31:0]     s3_data;

  logic            c1_sign;
  logic [IW-1:0]   c1_mag;
  logic [6:0]      c2_p;
  logic [6:0]      c2_shamt;
  logic [XW-1:0]   c2_ext;
  logic            c3_inc;
  logic [23:0]     c3_sum;
  logic [7:0]      c3_exp;

  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  assign out_valid = v3;
  assign out_data  = s3_data;

  // S1 combinational: sign extraction and magnitude
  always_comb begin
    c1_sign = !in_unsigned && in_data[IW-1];
    c1_mag  = c1_sign ? (~in_data + IW'(1)) : in_data;
  end

  // S2 combinational: leading-one search and left-justify below the hidden bit
  always_comb begin
    c2_p = '0;
    for (int unsigned i = 0; i < IW; i++) begin
      if (s1_mag[i]) c2_p = 7'(i);
    end
    c2_shamt = 7'(IW - 1) - c2_p;
    // the leading one shifts out of the top, leaving fraction/guard/sticky bits
    c2_ext = {s1_mag[IW-2:0], 25'd0} << c2_shamt;
  end

  // S3 combinational: round to nearest even, carry into the exponent
  always_comb begin
    c3_inc = s2_guard && (s2_sticky || s2_frac[0]);
    c3_sum = {1'b0, s2_frac} + 24'(c3_inc);
    c3_exp = s2_exp + 8'(c3_sum[23]);
  end

  // Stage 1 register: sign and magnitude
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sign <= c1_sign;
        s1_mag  <= c1_mag;
      end
    end
  end

  // Stage 2 register: normalised fraction, exponent, rounding bits
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2        <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_exp    <= '0;
      s2_frac   <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign   <= s1_sign;
        s2_zero   <= ~|s1_mag;
        s2_frac   <= c2_ext[XW-1 -: 23];
        s2_guard  <= c2_ext[XW-24];
        s2_sticky <= |c2_ext[XW-25:0];
        s2_exp    <= 8'd127 + 8'(c2_p);
      end
    end
  end

  // Stage 3 register: packed binary32 result, held while stalled
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v3      <= 1'b0;
      s3_data <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        s3_data <= s2_zero ? 32'h0000_0000 : {s2_sign, c3_exp, c3_sum[22:0]};
      end
    end
  end

`ifdef ITOF_PIPE_INEXACT_EN
  logic s3_inexact;

  assign out_inexact = s3_inexact;

  // Inexact flag travels with the stage 3 result
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s3_inexact <= 1'b0;
    end else if (ld3 && v2) begin
      s3_inexact <= s2_guard || s2_sticky;
    end
  end
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed and random checks of itof_pipe against an arithmetic
// reference conversion, with a scoreboard queue and cycle-stepped stimulus.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_unsigned = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] in_data16 = '0;
  logic        in_uns16 = 1'b0;
  logic        out_valid16;
  logic        out_ready16 = 1'b1;
  logic [31:0] out_data16;

`ifdef ITOF_PIPE_INEXACT_EN
  logic        out_inexact;
  logic        out_inexact16;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_emit = 0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] expq[$];
  bit          inxq[$];
  int          accq[$];

  always #5 clk = ~clk;

  itof_pipe #(.IW(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_unsigned (in_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef ITOF_PIPE_INEXACT_EN
    ,
    .out_inexact (out_inexact)
`endif
  );

  itof_pipe #(.IW(16)) dut16 (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid16),
    .in_ready    (in_ready16),
    .in_data     (in_data16),
    .in_unsigned (in_uns16),
    .out_valid   (out_valid16),
    .out_ready   (out_ready16),
    .out_data    (out_data16)
`ifdef ITOF_PIPE_INEXACT_EN
    ,
    .out_inexact (out_inexact16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {inexact, binary32} from the integer value by plain arithmetic
  function automatic logic [32:0] ref_of(input logic [31:0] d, input bit u);
    longint unsigned mag, q, rem, half;
    int p, sh;
    bit neg, inex;
    neg = !u && d[31];
    mag = neg ? ((64'd1 << 32) - {32'd0, d}) : {32'd0, d};
    if (mag == 0) return '0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    inex = 1'b0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {inex, neg, 8'(p + 127), q[22:0]};
  endfunction

  // One clock cycle: drive, sample at negedge, score, advance past posedge
  task automatic step(input bit v, input logic [31:0] d, input bit u, input bit r,
                      input bit usec, input logic [31:0] c, output bit acc, output bit rdy);
    logic [32:0] m;
    int a;
    bit xi;
    in_valid = v; in_data = d; in_unsigned = u; out_ready = r;
    @(negedge clk);
    acc = 1'b0;
    rdy = in_ready;
    if (rstn) begin
      if (prev_stall) chk("hold", out_data, prev_data);
      if (in_valid && in_ready) begin
        acc = 1'b1;
        m = ref_of(d, u);
        expq.push_back(usec ? c : m[31:0]);
        inxq.push_back(m[32]);
        accq.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        n_emit++;
        if (expq.size() == 0) begin
          chk("spurious", 32'(out_valid), 32'd0);
        end else begin
          chk("data", out_data, expq.pop_front());
          xi = inxq.pop_front();
`ifdef ITOF_PIPE_INEXACT_EN
          chk("inexact", 32'(out_inexact), 32'(xi));
`endif
          a = accq.pop_front();
          if (lat_chk) chk("latency", 32'(cyc - a), 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      expq.delete();
      inxq.delete();
      accq.delete();
      prev_stall = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [15:0] d, input bit u, input logic [31:0] e);
    int n;
    in_valid16 = 1'b1; in_data16 = d; in_uns16 = u; out_ready16 = 1'b1;
    @(negedge clk);
    chk("iw16_ready", 32'(in_ready16), 32'd1);
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid16 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("iw16_valid", 32'(out_valid16), 32'd1);
    chk("iw16_data", out_data16, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc, rdy;
    int got, e0;

    // reset
    rstn = 1'b0;
    repeat (3) step(0, 0, 0, 1, 0, 0, acc, rdy);
    rstn = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // basic values with latency tracking
    lat_chk = 1'b1;
    step(1, 32'd1,         0, 1, 1, 32'h3F80_0000, acc, rdy);
    step(1, 32'hFFFF_FFFF, 0, 1, 1, 32'hBF80_0000, acc, rdy);
    step(1, 32'd0,         0, 1, 1, 32'h0000_0000, acc, rdy);
    repeat (4) step(0, 0, 0, 1, 0, 0, acc, rdy);

    // extremes and ties
    step(1, 32'h8000_0000, 0, 1, 1, 32'hCF00_0000, acc, rdy);
    step(1, 32'h8000_0000, 1, 1, 1, 32'h4F00_0000, acc, rdy);
    step(1, 32'hFFFF_FFFF, 1, 1, 1, 32'h4F80_0000, acc, rdy);
    step(1, 32'h0100_0001, 0, 1, 1, 32'h4B80_0000, acc, rdy);
    step(1, 32'h0100_0003, 0, 1, 1, 32'h4B80_0002, acc, rdy);
    step(1, 32'h0100_0005, 0, 1, 1, 32'h4B80_0002, acc, rdy);
    step(1, 32'h0100_0000, 0, 1, 1, 32'h4B80_0000, acc, rdy);
    repeat (4) step(0, 0, 0, 1, 0, 0, acc, rdy);
    lat_chk = 1'b0;

    // backpressure: out_ready low for 6 cycles while streaming 1..5
    e0 = n_emit;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      step(got < 5, 32'(got + 1), 0, 0, 0, 0, acc, rdy);
      if (acc) got++;
    end
    chk("bp_accepted", 32'(got), 32'd3);
    chk("bp_head", out_data, 32'h3F80_0000);
    chk("bp_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 20 && got < 5; i++) begin
      step(1, 32'(got + 1), 0, 1, 0, 0, acc, rdy);
      if (acc) got++;
    end
    repeat (6) step(0, 0, 0, 1, 0, 0, acc, rdy);
    chk("bp_count", 32'(n_emit - e0), 32'd5);
    chk("bp_drain", 32'(expq.size()), 32'd0);

    // bubbles, then a one-cycle stall that the bubble absorbs
    lat_chk = 1'b1;
    step(1, 32'd7, 0, 1, 0, 0, acc, rdy);
    step(0, 0,     0, 1, 0, 0, acc, rdy);
    step(1, 32'd9, 0, 1, 0, 0, acc, rdy);
    lat_chk = 1'b0;
    step(1, 32'd11, 0, 0, 0, 0, acc, rdy);
    chk("bubble_ready", 32'(rdy), 32'd1);
    repeat (6) step(0, 0, 0, 1, 0, 0, acc, rdy);
    chk("bubble_drain", 32'(expq.size()), 32'd0);

    // reset with three in flight
    repeat (3) step(1, 32'h0000_0015, 0, 0, 0, 0, acc, rdy);
    rstn = 1'b0;
    step(0, 0, 0, 0, 0, 0, acc, rdy);
    rstn = 1'b1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    e0 = n_emit;
    repeat (6) step(0, 0, 0, 1, 0, 0, acc, rdy);
    chk("rst_mid_none", 32'(n_emit - e0), 32'd0);

    // random traffic, random data and signedness
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 100)) : -32'($urandom_range(0, 100));
        2:       d = (32'd1 << $urandom_range(0, 31)) ^ 32'($urandom_range(0, 3));
        default: d = $urandom & 32'h03FF_FFFF;
      endcase
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) != 0,
           $urandom_range(0, 3) != 0, 0, 0, acc, rdy);
    end
    repeat (8) step(0, 0, 0, 1, 0, 0, acc, rdy);
    chk("rand_drain", 32'(expq.size()), 32'd0);

    // 16-bit instance
    run16(16'hFFFF, 1'b1, 32'h477F_FF00);
    run16(16'h8000, 1'b0, 32'hC700_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
